// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM encoding, register
// address width and the byte-offset alignment mask.
package memory_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int          REG_AW     = 5;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/memory_stage_mem_wb.sv
// MEM/WB pipeline register. A stall cycle inserts a bubble (write enable and
// load select cleared, payload held); kill retires the instruction without a
// register write.
module mem_wb_reg
    import memory_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              kill,
    input  logic              ld_rdata,
    input  logic [width-1:0]  alu_out,
    input  logic [width-1:0]  rdata,
    input  logic [REG_AW-1:0] write_reg,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    output logic [width-1:0]  read_data_w,
    output logic [width-1:0]  alu_out_w,
    output logic [REG_AW-1:0] write_reg_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w
);

    logic [width-1:0]  read_data_q, read_data_d;
    logic [width-1:0]  alu_out_q, alu_out_d;
    logic [REG_AW-1:0] write_reg_q, write_reg_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    // Next-state: retire loads the payload, stall holds it and forces a bubble.
    always_comb begin
        read_data_d  = read_data_q;
        alu_out_d    = alu_out_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (!stall) begin
            alu_out_d    = alu_out;
            write_reg_d  = write_reg;
            reg_write_d  = reg_write & ~kill;
            mem_to_reg_d = mem_to_reg;
            if (ld_rdata) begin
                read_data_d = rdata;
            end
        end
    end

    // Register bank; reset clears everything so ResultW reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q  <= '0;
            alu_out_q    <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_out_q    <= alu_out_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign read_data_w  = read_data_q;
    assign alu_out_w    = alu_out_q;
    assign write_reg_w  = write_reg_q;
    assign reg_write_w  = reg_write_q;
    assign mem_to_reg_w = mem_to_reg_q;

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues req/ack data-memory accesses, stalls upstream while an
// access is outstanding and owns the MEM/WB register and ResultW mux.
// Optional watchdog on long waits is built when MEM_TIMEOUT_EN is defined.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int width          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [width-1:0]  ALUOutM,
    input  logic [width-1:0]  WriteDataM,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [width-1:0]  dmem_addr,
    output logic [width-1:0]  dmem_wdata,
    input  logic              dmem_ack,
    input  logic [width-1:0]  dmem_rdata,
    output logic              StallM,
    output logic [width-1:0]  ReadDataW,
    output logic [width-1:0]  ALUOutW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [width-1:0]  ResultW,
    output logic              mem_err
);

    mem_state_t state_q, state_d;
    logic       mem_op, misaligned, access, req, timeout;

    // Classify the instruction: memory op, misaligned, or a real access.
    always_comb begin
        mem_op     = MemtoRegM | MemWriteM;
        misaligned = mem_op & ((ALUOutM[1:0] & ALIGN_MASK) != 2'b00);
        access     = mem_op & ~misaligned;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait-cycle counter: zero while idle so it starts cleared on WAIT entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!dmem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout = (state_q == WAIT) & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // FSM next state and raw request.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                req = access;
                if (access && !dmem_ack) state_d = WAIT;
            end
            WAIT: begin
                req = ~timeout;
                if (dmem_ack || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Bus and hazard outputs are forced quiet while reset is held.
    assign dmem_req   = req & ~rst;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUOutM;
    assign dmem_wdata = WriteDataM;
    assign StallM     = access & ~dmem_ack & ~timeout & ~rst;
    assign mem_err    = (misaligned | timeout) & ~rst;

    mem_wb_reg #(.width(width)) u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .stall        (StallM),
        .kill         (misaligned | timeout),
        .ld_rdata     (access & dmem_ack),
        .alu_out      (ALUOutM),
        .rdata        (dmem_rdata),
        .write_reg    (WriteRegM),
        .reg_write    (RegWriteM),
        .mem_to_reg   (MemtoRegM),
        .read_data_w  (ReadDataW),
        .alu_out_w    (ALUOutW),
        .write_reg_w  (WriteRegW),
        .reg_write_w  (RegWriteW),
        .mem_to_reg_w (MemtoRegW)
    );

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
MEM stage of the 5-stage pipeline, directly downstream of the execute stage. Consumes the EX/MEM register outputs (ALU result, store data, destination register, control bits) and drives a req/ack data-memory bus that may take multiple cycles. Stalls the upstream pipeline while an access is outstanding. Holds the MEM/WB pipeline register and produces ResultW and the forwarding/writeback signals.

Parameters:
width, 32, datapath and address width
TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
ALUOutM  in  width  address for memory access, or result for ALU instructions
WriteDataM  in  width  store data
WriteRegM  in  5  destination register
RegWriteM  in  1  register write enable
MemtoRegM  in  1  load instruction
MemWriteM  in  1  store instruction
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  width  byte address, equal to ALUOutM
dmem_wdata  out  width  equal to WriteDataM
dmem_ack  in  1  access complete; rdata valid in the same cycle
dmem_rdata  in  width  load data
StallM  out  1  to hazard unit; freezes the IF/ID/EX/MEM registers
ReadDataW  out  width  registered load data
ALUOutW  out  width  registered ALU result
WriteRegW  out  5  registered destination
RegWriteW  out  1  registered write enable
MemtoRegW  out  1  registered select
ResultW  out  width  MemtoRegW ? ReadDataW : ALUOutW (combinational)
mem_err  out  1  one-cycle pulse on a misaligned access or a timeout

Behaviour:
- access = (MemtoRegM | MemWriteM) & ~misaligned, where misaligned = (MemtoRegM | MemWriteM) & (ALUOutM[1:0] != 0).
- FSM states: IDLE, WAIT.
- IDLE:
  - dmem_req = access.
  - If access & dmem_ack: zero-wait completion; the instruction retires this cycle; stay in IDLE.
  - If access & ~dmem_ack: go to WAIT.
- WAIT:
  - dmem_req = 1. Inputs are held stable by the upstream stall.
  - On dmem_ack: retire the instruction and go to IDLE.
- dmem_we = MemWriteM; dmem_addr and dmem_wdata are combinational pass-throughs.
- StallM = access & ~dmem_ack (combinational, same cycle).
- MEM/WB register update on every clk edge:
  - Retire cycle (StallM = 0): load ALUOutM, WriteRegM, MemtoRegM and RegWriteM; load ReadDataW from dmem_rdata when dmem_ack, otherwise hold ReadDataW.
  - Stall cycle: bubble. RegWriteW <= 0, MemtoRegW <= 0, other W registers hold.
- Misaligned access:
  - No request is issued and StallM stays 0.
  - Retire with RegWriteW <= 0.
  - mem_err = 1 for that cycle.
- Stores retire with RegWriteW = RegWriteM as supplied (normally 0).
- Latency:
  - ALU-only instruction: W registers valid 1 cycle after M.
  - Memory access: 1 cycle after the ack cycle.
- Reset, including assertion mid-access:
  - FSM goes to IDLE immediately.
  - All W registers read 0, so ResultW = 0.
  - dmem_req and StallM are 0 while rst is high, and mem_err = 0.
  - The outstanding access is abandoned; a late ack in IDLE with no access is ignored.
- Ack in IDLE with access = 0: ignored, no state change.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: drop dmem_req, release StallM, retire the instruction as a bubble (RegWriteW <= 0), pulse mem_err, return to IDLE.
  - Counter width: $clog2(TIMEOUT_CYCLES)+1.
- Not defined: WAIT holds indefinitely until ack; no counter logic is built.

Decomposition:
- Shared pipeline package:
  - FSM state encoding: IDLE=1'b0, WAIT=1'b1.
  - Register address width (5).
  - Byte-offset alignment mask (2'b11).
- One sub-module: mem_wb_reg, the MEM/WB pipeline register with bubble insert. The FSM and the ResultW mux stay in memory_stage.

Test Plan:
- ALU op: ALUOutM=0x0000_0042, RegWriteM=1, WriteRegM=5 -> next cycle RegWriteW=1, WriteRegW=5, ResultW=0x42; dmem_req never asserted.
- Zero-wait load: MemtoRegM=1, addr 0x100, ack in the same cycle with rdata 0xDEAD_BEEF -> StallM stays 0; next cycle ResultW=0xDEAD_BEEF, RegWriteW=1.
- 3-wait store: MemWriteM=1, addr 0x200, data 0x1234, ack on the 4th cycle -> dmem_req/dmem_we high for 4 cycles, StallM high for 3, RegWriteW=0 during stalls, addr/data stable throughout.
- Misaligned load: addr 0x102 -> dmem_req=0, StallM=0, mem_err pulse, next cycle RegWriteW=0.
- Reset in WAIT: assert rst in the 2nd wait cycle -> dmem_req and StallM 0 immediately, all W outputs 0; an ack after reset release is ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> stall ends after 4 cycles, mem_err pulse, FSM back in IDLE, RegWriteW=0.
